// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   // Requester side (CPU core / testbench)
   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   // Divider side
   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock,
// signed/unsigned, RISC-V divide-by-zero and overflow semantics.
module seq_divider #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic         clk,
   input  logic         reset,
   seq_divider_if.slave bus
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FINISH
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   prem_q;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic             q_neg_q;
   logic             r_neg_q;
   logic             dbz_q;

   logic             a_neg_c;
   logic             b_neg_c;
   logic [WIDTH-1:0] a_mag_c;
   logic [WIDTH-1:0] b_mag_c;
   logic             zero_c;
   logic             ovf_c;

   logic [WIDTH+1:0] shifted_c;
   logic [WIDTH+1:0] trial_c;
   logic [WIDTH:0]   prem_d;
   logic [WIDTH-1:0] shreg_d;
   logic [WIDTH-1:0] quo_fin_c;
   logic [WIDTH-1:0] rem_fin_c;

   // Operand magnitudes and special-case detection for the accept cycle
   always_comb begin
      a_neg_c = bus.signed_op & bus.dividend[WIDTH-1];
      b_neg_c = bus.signed_op & bus.divisor[WIDTH-1];
      // Most-negative value maps to unsigned 2^(WIDTH-1), which fits
      a_mag_c = a_neg_c ? WIDTH'(-bus.dividend) : bus.dividend;
      b_mag_c = b_neg_c ? WIDTH'(-bus.divisor)  : bus.divisor;
      zero_c  = (bus.divisor == '0);
      ovf_c   = bus.signed_op & (bus.dividend == MIN_NEG) & (bus.divisor == '1);
   end

   // One restoring step plus the sign-corrected result of that step
   always_comb begin
      shifted_c = {prem_q, shreg_q[WIDTH-1]};
      trial_c   = shifted_c - {2'b00, dvs_q};
      prem_d    = trial_c[WIDTH+1] ? shifted_c[WIDTH:0] : trial_c[WIDTH:0];
      shreg_d   = {shreg_q[WIDTH-2:0], ~trial_c[WIDTH+1]};
      quo_fin_c = q_neg_q ? WIDTH'(-shreg_d) : shreg_d;
      rem_fin_c = r_neg_q ? WIDTH'(-prem_d[WIDTH-1:0]) : prem_d[WIDTH-1:0];
   end

   // Control FSM and datapath registers; results load on entry to FINISH
   // so they are already valid while done is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         shreg_q <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  q_neg_q <= a_neg_c ^ b_neg_c;
                  r_neg_q <= a_neg_c;
                  dvs_q   <= b_mag_c;
                  prem_q  <= '0;
                  shreg_q <= a_mag_c;
                  cnt_q   <= CNT_W'(WIDTH - 1);
                  if (zero_c) begin
                     quo_q   <= '1;
                     rem_q   <= bus.dividend;
                     dbz_q   <= 1'b1;
                     state_q <= S_FINISH;
                  end else if (ovf_c) begin
                     quo_q   <= MIN_NEG;
                     rem_q   <= '0;
                     dbz_q   <= 1'b0;
                     state_q <= S_FINISH;
                  end else begin
                     state_q <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               prem_q  <= prem_d;
               shreg_q <= shreg_d;
               if (cnt_q == '0) begin
                  quo_q   <= quo_fin_c;
                  rem_q   <= rem_fin_c;
                  dbz_q   <= 1'b0;
                  state_q <= S_FINISH;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_FINISH: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Status decoded straight from the state register
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = (state_q == S_FINISH);
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): vector table plus
// handshake, back-to-back and reset corner sequences.
module tb_seq_divider;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned NVEC  = 14;

   typedef struct {
      logic        sop;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          lat;
   } vec_t;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   seq_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive operands at the negedge, start is accepted at the next posedge
   task automatic start_op(input logic sop, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.signed_op = sop;
      bus.dividend  = a;
      bus.divisor   = b;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Called 1 time unit after the accepting edge (cycle 1). Returns the
   // cycle in which done is seen and the number of busy cycles up to it.
   // A stray start with other operands is pulsed in cycle inject_at.
   task automatic wait_done(input int inject_at, output int lat, output int bcnt);
      int cyc;
      cyc  = 1;
      bcnt = 0;
      lat  = 999;
      while (cyc <= 100) begin
         if (inject_at != 0 && cyc == inject_at) begin
            bus.start     = 1'b1;
            bus.signed_op = 1'b1;
            bus.dividend  = 32'd50;
            bus.divisor   = 32'd3;
         end else if (inject_at != 0 && cyc == inject_at + 1) begin
            bus.start = 1'b0;
         end
         if (bus.busy) bcnt++;
         if (bus.done) begin
            lat = cyc;
            break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.start = 1'b0;
   endtask

   vec_t vecs[NVEC];

   initial begin
      int lat;
      int bcnt;
      int cyc;
      int first;
      int second;
      int done_seen;
      logic gap_busy;

      n_chk  = 0;
      n_fail = 0;

      //            sop   dividend       divisor        quotient       remainder     dbz  lat
      vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,        1'b0, 33};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0, 33};
      vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,        1'b0, 33};
      vecs[3]  = '{1'b0, 32'h12345678,  32'h0,         32'hFFFFFFFF,  32'h12345678, 1'b1, 1};
      vecs[4]  = '{1'b1, 32'h12345678,  32'h0,         32'hFFFFFFFF,  32'h12345678, 1'b1, 1};
      vecs[5]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,        1'b0, 1};
      vecs[6]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h0,         32'h80000000, 1'b0, 33};
      vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF,  32'hF,        1'b0, 33};
      vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE, 1'b0, 33};
      vecs[9]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'h0,        1'b0, 33};
      vecs[10] = '{1'b1, 32'h80000000,  32'd1,         32'h80000000,  32'h0,        1'b0, 33};
      vecs[11] = '{1'b0, 32'd5,         32'd9,         32'd0,         32'd5,        1'b0, 33};
      vecs[12] = '{1'b1, 32'hFFFFFFFF,  32'h0,         32'hFFFFFFFF,  32'hFFFFFFFF, 1'b1, 1};
      vecs[13] = '{1'b1, 32'h80000000,  32'd2,         32'hC0000000,  32'h0,        1'b0, 33};

      bus.start     = 1'b0;
      bus.signed_op = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      reset         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_quo",  bus.quotient, 32'd0);
      check("rst_rem",  bus.remainder, 32'd0);
      check("rst_dbz",  32'(bus.div_by_zero), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < int'(NVEC); i++) begin
         start_op(vecs[i].sop, vecs[i].a, vecs[i].b);
         wait_done(0, lat, bcnt);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
         check($sformatf("v%0d_quo", i), bus.quotient, vecs[i].q);
         check($sformatf("v%0d_rem", i), bus.remainder, vecs[i].r);
         check($sformatf("v%0d_dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].dbz));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
         check($sformatf("v%0d_idle_busy", i), 32'(bus.busy), 32'd0);
      end

      // Stray start 5 cycles into an operation is ignored
      start_op(1'b0, 32'd100, 32'd7);
      wait_done(5, lat, bcnt);
      check("hs_latency", 32'(lat), 32'd33);
      check("hs_quo", bus.quotient, 32'd14);
      check("hs_rem", bus.remainder, 32'd2);
      repeat (6) @(posedge clk);
      #1;
      check("hs_hold_quo", bus.quotient, 32'd14);
      check("hs_hold_rem", bus.remainder, 32'd2);
      check("hs_hold_done", 32'(bus.done), 32'd0);
      // Operand latch leaves the previous result visible
      start_op(1'b0, 32'd1000, 32'd10);
      check("hs_latch_keeps_quo", bus.quotient, 32'd14);
      check("hs_latch_busy", 32'(bus.busy), 32'd1);
      wait_done(0, lat, bcnt);
      check("hs2_quo", bus.quotient, 32'd100);
      check("hs2_rem", bus.remainder, 32'd0);
      @(posedge clk);
      #1;

      // start held high: back-to-back operations with one IDLE gap
      @(negedge clk);
      bus.signed_op = 1'b0;
      bus.dividend  = 32'd20;
      bus.divisor   = 32'd3;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      cyc      = 1;
      first    = 0;
      second   = 0;
      gap_busy = 1'b1;
      while (cyc < 200 && second == 0) begin
         if (first != 0 && cyc == first + 1) gap_busy = bus.busy;
         if (bus.done) begin
            if (first == 0) first = cyc;
            else second = cyc;
         end
         if (second == 0) begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      bus.start = 1'b0;
      check("b2b_first_done", 32'(first), 32'd33);
      check("b2b_gap_idle", 32'(gap_busy), 32'd0);
      check("b2b_second_done", 32'(second), 32'd67);
      check("b2b_quo", bus.quotient, 32'd6);
      check("b2b_rem", bus.remainder, 32'd2);
      @(posedge clk);
      #1;
      check("b2b_no_third", 32'(bus.busy), 32'd0);

      // Reset in the middle of CALC
      start_op(1'b0, 32'd100, 32'd7);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_done", 32'(bus.done), 32'd0);
      check("mid_rst_quo", bus.quotient, 32'd0);
      check("mid_rst_rem", bus.remainder, 32'd0);
      done_seen = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus.done) done_seen++;
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) done_seen++;
      end
      check("mid_rst_no_done", 32'(done_seen), 32'd0);
      start_op(1'b0, 32'hFFFFFFFF, 32'h10);
      wait_done(0, lat, bcnt);
      check("post_rst_latency", 32'(lat), 32'd33);
      check("post_rst_quo", bus.quotient, 32'h0FFFFFFF);
      check("post_rst_rem", bus.remainder, 32'hF);
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
